// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: captures completed UART frames, checks parity and buffers payload + error flag
//   clk          system clock, all state on posedge
//   reset_n      asynchronous active-low reset
//   rec_complete frame-done strobe (rising edge captured once, may stay high)
//   data_in      9-bit receiver shift register
//   parity       00/11 none, 01 odd, 10 even
//   clear        synchronous flush of FIFO, overrun and err_cnt (highest priority)
//   rd_en        pop head entry
//   rd_data      head payload, first-word-fall-through; holds last shown value while empty
//   rd_perr      head parity-error flag
//   empty/full   occupancy flags
//   count        entries held
//   overrun      sticky: frame dropped because FIFO was full
//   err_cnt      saturating count of accepted frames with parity error
module rx_frame_fifo #(
    parameter int DEPTH = 8,
    parameter int ERR_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rec_complete,
    input  logic [8:0]               data_in,
    input  logic [1:0]               parity,
    input  logic                     clear,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_perr,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic [ERR_W-1:0]         err_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic             rec_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overrun_q, overrun_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [8:0]       last_q, last_d;
    logic [8:0]       mem [DEPTH];
    logic [8:0]       head;
    logic [7:0]       payload;
    logic             wr_ev, do_wr, do_rd, perr, has_par;
    assign wr_ev   = rec_complete & ~rec_q;
    assign has_par = (parity == 2'b01) | (parity == 2'b10);
    assign payload = has_par ? data_in[7:0] : data_in[8:1];
    assign perr    = (parity == 2'b01) ? ~(^data_in) : (parity == 2'b10) ? ^data_in : 1'b0;
    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    // A full FIFO still accepts a frame when the head is popped in the same cycle.
    assign do_wr   = wr_ev & ~clear & (~full | rd_en);
    assign do_rd   = rd_en & ~clear & ~empty;
    assign head    = mem[rd_ptr_q];
    assign rd_data = empty ? last_q[7:0] : head[7:0];
    assign rd_perr = empty ? last_q[8] : head[8];
    assign count   = count_q;
    assign overrun = overrun_q;
    assign err_cnt = err_cnt_q;
    always_comb begin
        wr_ptr_d  = clear ? '0 : do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = clear ? '0 : do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = clear ? '0 : (do_wr & ~do_rd) ? count_q + 1'b1 : (do_rd & ~do_wr) ? count_q - 1'b1 : count_q;
        overrun_d = clear ? 1'b0 : (overrun_q | (wr_ev & full & ~rd_en));
        err_cnt_d = clear ? '0 : (do_wr & perr & ~(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
        // Remember what is on the read port so it stays put once the FIFO drains.
        last_d    = empty ? last_q : head;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rec_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
            last_q    <= '0;
        end else begin
            rec_q     <= rec_complete;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
            last_q    <= last_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= {perr, payload};
    end
endmodule

// File: tb/tb_rx_frame_fifo.sv
// tb_rx_frame_fifo: table-driven and scoreboard-checked bench for rx_frame_fifo
module tb_rx_frame_fifo;
    logic       clk = 1'b0;
    logic       reset_n, rec_complete, clear, rd_en;
    logic [8:0] data_in;
    logic [1:0] parity;
    logic [7:0] rd_data;
    logic       rd_perr, empty, full, overrun;
    logic [3:0] count;
    logic [7:0] err_cnt;
    typedef struct { logic [1:0] par; logic [8:0] din; logic [7:0] exp_d; logic exp_p; } vec_t;
    typedef struct { logic [7:0] d; logic p; } ent_t;
    vec_t vecs[10];
    ent_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   err_model = 0;
    rx_frame_fifo dut (
        .clk(clk), .reset_n(reset_n), .rec_complete(rec_complete), .data_in(data_in),
        .parity(parity), .clear(clear), .rd_en(rd_en), .rd_data(rd_data), .rd_perr(rd_perr),
        .empty(empty), .full(full), .count(count), .overrun(overrun), .err_cnt(err_cnt)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic write(input logic [1:0] p, input logic [8:0] d, input logic [7:0] ed, input logic ep, input bit acc);
        parity = p;
        data_in = d;
        rec_complete = 1'b1;
        if (acc) begin
            sb.push_back('{ed, ep});
            if (ep && err_model < 255) err_model++;
        end
        tick;
        rec_complete = 1'b0;
        tick;
    endtask
    task automatic pop_chk(input string nm);
        ent_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, nothing expected", nm);
        end else begin
            e = sb.pop_front();
            check({nm, "_data"}, 32'(rd_data), 32'(e.d));
            check({nm, "_perr"}, 32'(rd_perr), 32'(e.p));
        end
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
    endtask
    initial begin
        ent_t e;
        vecs[0] = '{2'b01, 9'h1A5, 8'hA5, 1'b0};
        vecs[1] = '{2'b10, 9'h1A5, 8'hA5, 1'b1};
        vecs[2] = '{2'b00, 9'h14A, 8'hA5, 1'b0};
        vecs[3] = '{2'b11, 9'h0FF, 8'h7F, 1'b0};
        vecs[4] = '{2'b01, 9'h000, 8'h00, 1'b1};
        vecs[5] = '{2'b10, 9'h000, 8'h00, 1'b0};
        vecs[6] = '{2'b01, 9'h155, 8'h55, 1'b0};
        vecs[7] = '{2'b10, 9'h0FF, 8'hFF, 1'b0};
        vecs[8] = '{2'b01, 9'h0FF, 8'hFF, 1'b1};
        vecs[9] = '{2'b10, 9'h101, 8'h01, 1'b0};
        reset_n = 1'b0;
        rec_complete = 1'b0;
        clear = 1'b0;
        rd_en = 1'b0;
        data_in = '0;
        parity = '0;
        repeat (3) tick;
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_err", 32'(err_cnt), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_rd_perr", 32'(rd_perr), 0);
        reset_n = 1'b1;
        tick;
        for (int i = 0; i < 10; i++) begin
            write(vecs[i].par, vecs[i].din, vecs[i].exp_d, vecs[i].exp_p, 1'b1);
            check($sformatf("vec%0d_empty", i), 32'(empty), 0);
            check($sformatf("vec%0d_err", i), 32'(err_cnt), 32'(err_model));
            pop_chk($sformatf("vec%0d", i));
            check($sformatf("vec%0d_drained", i), 32'(empty), 1);
        end
        parity = 2'b00;
        data_in = 9'h0AA;
        rec_complete = 1'b1;
        sb.push_back('{8'h55, 1'b0});
        repeat (3) tick;
        rec_complete = 1'b0;
        tick;
        check("long_strobe_count", 32'(count), 1);
        pop_chk("long_strobe");
        check("long_pop_empty", 32'(empty), 1);
        check("long_pop_count", 32'(count), 0);
        check("pre_clear_err", 32'(err_cnt), 32'(err_model));
        clear = 1'b1;
        tick;
        clear = 1'b0;
        sb.delete();
        err_model = 0;
        for (int i = 0; i < 8; i++) write(2'b00, {8'(i), 1'b0}, 8'(i), 1'b0, 1'b1);
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 8);
        check("fill_overrun", 32'(overrun), 0);
        write(2'b01, 9'h000, 8'h00, 1'b1, 1'b0);
        check("drop_overrun", 32'(overrun), 1);
        check("drop_count", 32'(count), 8);
        check("drop_err", 32'(err_cnt), 0);
        for (int i = 0; i < 8; i++) pop_chk($sformatf("order%0d", i));
        check("drain_empty", 32'(empty), 1);
        check("drain_overrun", 32'(overrun), 1);
        check("hold_rd_data", 32'(rd_data), 8'h07);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("rd_empty_count", 32'(count), 0);
        check("rd_empty_empty", 32'(empty), 1);
        check("rd_empty_hold", 32'(rd_data), 8'h07);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        check("clear_overrun", 32'(overrun), 0);
        for (int i = 0; i < 8; i++) write(2'b00, {8'h10 + 8'(i), 1'b0}, 8'h10 + 8'(i), 1'b0, 1'b1);
        e = sb.pop_front();
        check("both_full_head", 32'(rd_data), 32'(e.d));
        parity = 2'b00;
        data_in = {8'h5A, 1'b0};
        rec_complete = 1'b1;
        rd_en = 1'b1;
        sb.push_back('{8'h5A, 1'b0});
        tick;
        rec_complete = 1'b0;
        rd_en = 1'b0;
        check("both_full_count", 32'(count), 8);
        check("both_full_overrun", 32'(overrun), 0);
        check("both_full_advance", 32'(rd_data), 8'h11);
        tick;
        for (int i = 0; i < 8; i++) pop_chk($sformatf("both_drain%0d", i));
        check("both_drained", 32'(empty), 1);
        data_in = {8'h66, 1'b0};
        rec_complete = 1'b1;
        rd_en = 1'b1;
        sb.push_back('{8'h66, 1'b0});
        tick;
        rec_complete = 1'b0;
        rd_en = 1'b0;
        check("both_empty_count", 32'(count), 1);
        check("both_empty_data", 32'(rd_data), 8'h66);
        tick;
        write(2'b10, 9'h1A5, 8'hA5, 1'b1, 1'b1);
        check("pre_clr_err", 32'(err_cnt), 1);
        data_in = {8'h77, 1'b0};
        rec_complete = 1'b1;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        sb.delete();
        err_model = 0;
        check("clr_wr_count", 32'(count), 0);
        check("clr_wr_empty", 32'(empty), 1);
        check("clr_wr_err", 32'(err_cnt), 0);
        tick;
        rec_complete = 1'b0;
        check("clr_no_recapture", 32'(count), 0);
        tick;
        for (int i = 0; i < 260; i++) begin
            write(2'b01, 9'h000, 8'h00, 1'b1, 1'b1);
            pop_chk("sat");
        end
        check("err_saturate", 32'(err_cnt), 255);
        check("err_model_sat", 32'(err_cnt), 32'(err_model));
        for (int i = 0; i < 3; i++) write(2'b00, {8'hC0 + 8'(i), 1'b0}, 8'hC0 + 8'(i), 1'b0, 1'b1);
        check("midfill_count", 32'(count), 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_empty", 32'(empty), 1);
        check("async_count", 32'(count), 0);
        check("async_err", 32'(err_cnt), 0);
        check("async_rd_data", 32'(rd_data), 0);
        sb.delete();
        tick;
        reset_n = 1'b1;
        tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
